// File: rtl/tx_pcs_pkg.sv
// Shared constants and types for the 64b/66b transmit PCS blocks.
// Holds the coded block layout, the scrambler geometry (x^58 + x^39 + 1)
// and the legal sync header values.
package tx_pcs_pkg;

  localparam int LEN_CODED_BLOCK = 66;
  localparam int LEN_SH          = 2;
  localparam int LEN_PAYLOAD     = LEN_CODED_BLOCK - LEN_SH;
  localparam int LEN_SCR_STATE   = 58;

  // State bit positions feeding the scrambler XOR (x^39 and x^58 terms).
  localparam int SCR_TAP_A = 38;
  localparam int SCR_TAP_B = 57;

  localparam logic [LEN_SH-1:0] SH_DATA = 2'b01;
  localparam logic [LEN_SH-1:0] SH_CTRL = 2'b10;

  // One coded block: sync header in the two MSBs, payload bit 0 sent first.
  typedef struct packed {
    logic [LEN_SH-1:0]      sh;
    logic [LEN_PAYLOAD-1:0] payload;
  } codedBlock_t;

  // Any header that is neither data nor control is malformed (00 or 11).
  function automatic logic isBadHeader(input logic [LEN_SH-1:0] sh);
    return !((sh == SH_DATA) || (sh == SH_CTRL));
  endfunction

endpackage

// File: rtl/tx_scrambler_multilane_if.sv
// Streaming interface of the multilane scrambler: input beat channel
// (i_data/i_valid/o_ready) and output beat channel (o_data/o_valid/i_ready).
// Signal names are seen from the scrambler's point of view.
interface tx_scrambler_multilane_if #(
  parameter int NBLOCKS         = 2,
  parameter int LEN_CODED_BLOCK = 66
);

  logic [NBLOCKS*LEN_CODED_BLOCK-1:0] i_data;
  logic                               i_valid;
  logic                               o_ready;
  logic [NBLOCKS*LEN_CODED_BLOCK-1:0] o_data;
  logic                               o_valid;
  logic                               i_ready;

  // Scrambler side.
  modport slave (
    input  i_data, i_valid, i_ready,
    output o_ready, o_data, o_valid
  );

  // Upstream/downstream side (encoder and lane distribution).
  modport master (
    output i_data, i_valid, i_ready,
    input  o_ready, o_data, o_valid
  );

endinterface

// File: rtl/scrambler_block_step.sv
// Combinational scrambler step for one 66b block: walks the 64 payload
// bits through the x^58 + x^39 + 1 self-synchronous scrambler, bit 0 first,
// and reports whether the sync header is malformed.
module scrambler_block_step
  import tx_pcs_pkg::*;
(
  input  codedBlock_t              blockIn_i,
  input  logic [LEN_SCR_STATE-1:0] state_i,
  output logic [LEN_PAYLOAD-1:0]   payload_o,
  output logic [LEN_SCR_STATE-1:0] state_o,
  output logic                     shErr_o
);

  logic [LEN_SCR_STATE-1:0] walkState;
  logic [LEN_PAYLOAD-1:0]   scrPayload;
  logic                     scrBit;

  // Serial scrambler unrolled over the payload; each scrambled bit is
  // shifted into the state before the next bit is processed.
  always_comb begin
    walkState  = state_i;
    scrPayload = '0;
    scrBit     = 1'b0;
    for (int i = 0; i < LEN_PAYLOAD; i++) begin
      scrBit        = blockIn_i.payload[i] ^ walkState[SCR_TAP_A] ^ walkState[SCR_TAP_B];
      scrPayload[i] = scrBit;
      walkState     = {walkState[LEN_SCR_STATE-2:0], scrBit};
    end
  end

  assign payload_o = scrPayload;
  assign state_o   = walkState;
  assign shErr_o   = isBadHeader(blockIn_i.sh);

endmodule

// File: rtl/tx_scrambler_multilane.sv
// 64b/66b transmit scrambler handling NBLOCKS coded blocks per beat.
// Headers pass through, payloads are scrambled (or bypassed while the
// scrambler state keeps advancing), malformed headers are counted with
// saturation. One-entry output register with valid/ready handshake.
// Optional feature: define TX_SCRAMBLER_TEST_PATTERN_EN to add i_test_mode,
// which replaces every accepted block with {SH_DATA, 64'h0} so the output
// is the scrambled-zero test pattern.
module tx_scrambler_multilane #(
  parameter int          NBLOCKS         = 2,
  parameter int          LEN_CODED_BLOCK = 66,
  parameter logic [57:0] SEED            = 58'd0,
  parameter int          ERR_CNT_W       = 16
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_enable,
  input  logic                    i_bypass,
  input  logic                    i_seed_load,
`ifdef TX_SCRAMBLER_TEST_PATTERN_EN
  input  logic                    i_test_mode,
`endif
  tx_scrambler_multilane_if.slave bus,
  output logic [ERR_CNT_W-1:0]    o_sh_err_count
);
  import tx_pcs_pkg::*;

  localparam int SUM_W = ERR_CNT_W + 4;

  logic                               testMode;
  logic                               accept;
  logic                               outValid_q;
  logic [NBLOCKS*LEN_CODED_BLOCK-1:0] outData_q;
  logic [NBLOCKS*LEN_CODED_BLOCK-1:0] outData_d;
  logic [LEN_SCR_STATE-1:0]           scrState_q;
  logic [ERR_CNT_W-1:0]               errCount_q;
  logic [ERR_CNT_W-1:0]               errCount_d;
  logic [LEN_SCR_STATE-1:0]           chainState [0:NBLOCKS];
  codedBlock_t                        stepIn     [NBLOCKS];
  logic [LEN_PAYLOAD-1:0]             stepPayload[NBLOCKS];
  logic [NBLOCKS-1:0]                 shErr;
  logic [SUM_W-1:0]                   errAdd;
  logic [SUM_W-1:0]                   errSum;

`ifdef TX_SCRAMBLER_TEST_PATTERN_EN
  assign testMode = i_test_mode;
`else
  assign testMode = 1'b0;
`endif

  assign bus.o_ready    = i_enable && (!outValid_q || bus.i_ready);
  assign accept         = bus.i_valid && bus.o_ready;
  assign bus.o_valid    = outValid_q;
  assign bus.o_data     = outData_q;
  assign o_sh_err_count = errCount_q;

  assign chainState[0] = scrState_q;

  // Block 0 is earliest in time, so the state ripples from block 0 upward.
  // Forced test-pattern blocks carry a legal header and never count as errors.
  for (genvar k = 0; k < NBLOCKS; k++) begin : g_lane
    assign stepIn[k] = testMode ? {SH_DATA, {LEN_PAYLOAD{1'b0}}}
                                : bus.i_data[k*LEN_CODED_BLOCK +: LEN_CODED_BLOCK];

    scrambler_block_step u_step (
      .blockIn_i (stepIn[k]),
      .state_i   (chainState[k]),
      .payload_o (stepPayload[k]),
      .state_o   (chainState[k+1]),
      .shErr_o   (shErr[k])
    );

    assign outData_d[k*LEN_CODED_BLOCK +: LEN_CODED_BLOCK] =
      {stepIn[k].sh, i_bypass ? stepIn[k].payload : stepPayload[k]};
  end

  // Add this beat's malformed-header count and clamp at all-ones.
  always_comb begin
    errAdd = '0;
    for (int k = 0; k < NBLOCKS; k++) begin
      errAdd = errAdd + SUM_W'(shErr[k]);
    end
    errSum     = SUM_W'(errCount_q) + errAdd;
    errCount_d = (errSum > SUM_W'({ERR_CNT_W{1'b1}})) ? {ERR_CNT_W{1'b1}}
                                                      : errSum[ERR_CNT_W-1:0];
  end

  // Output register, scrambler state and error counter; a seed load in the
  // same cycle as an accept lets the beat use the old state but wins the update.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      outData_q  <= '0;
      outValid_q <= 1'b0;
      scrState_q <= SEED;
      errCount_q <= '0;
    end else begin
      if (accept) begin
        outData_q  <= outData_d;
        outValid_q <= 1'b1;
        errCount_q <= errCount_d;
      end else if (bus.i_ready) begin
        outValid_q <= 1'b0;
      end
      if (i_seed_load) begin
        scrState_q <= SEED;
      end else if (accept) begin
        scrState_q <= chainState[NBLOCKS];
      end
    end
  end

endmodule

// File: tb/tb_tx_scrambler_multilane.sv
// Directed testbench for tx_scrambler_multilane. Main instance: NBLOCKS=3,
// SEED all ones, 4-bit error counter. Second instance: NBLOCKS=2, SEED=0.
// Inputs change on the falling clock edge; outputs are checked there too.
module tb_tx_scrambler_multilane;

  localparam int          NB     = 3;
  localparam int          BW     = 66;
  localparam logic [57:0] SEED_M = {58{1'b1}};
  localparam logic [63:0] ONES_ZERO_PAT = 64'h03FF_FF80_0000_0000;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       bypass;
  logic       seedLoad;
  logic [3:0] errCountM;
  logic [15:0] errCountZ;
`ifdef TX_SCRAMBLER_TEST_PATTERN_EN
  logic       testMode = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  tx_scrambler_multilane_if #(.NBLOCKS(3), .LEN_CODED_BLOCK(66)) busM ();
  tx_scrambler_multilane_if #(.NBLOCKS(2), .LEN_CODED_BLOCK(66)) busZ ();

  tx_scrambler_multilane #(
    .NBLOCKS(3), .LEN_CODED_BLOCK(66), .SEED(SEED_M), .ERR_CNT_W(4)
  ) dut (
    .i_clock       (clock),
    .i_reset       (reset),
    .i_enable      (enable),
    .i_bypass      (bypass),
    .i_seed_load   (seedLoad),
`ifdef TX_SCRAMBLER_TEST_PATTERN_EN
    .i_test_mode   (testMode),
`endif
    .bus           (busM.slave),
    .o_sh_err_count(errCountM)
  );

  tx_scrambler_multilane #(
    .NBLOCKS(2), .LEN_CODED_BLOCK(66), .SEED(58'd0), .ERR_CNT_W(16)
  ) dutZ (
    .i_clock       (clock),
    .i_reset       (reset),
    .i_enable      (enable),
    .i_bypass      (bypass),
    .i_seed_load   (seedLoad),
`ifdef TX_SCRAMBLER_TEST_PATTERN_EN
    .i_test_mode   (testMode),
`endif
    .bus           (busZ.slave),
    .o_sh_err_count(errCountZ)
  );

  // Bit-serial reference: scramble (descr=0) or descramble (descr=1) 64 bits.
  task automatic scrRun(input logic [63:0] d, input bit descr, input logic [57:0] sIn,
                        output logic [63:0] q, output logic [57:0] sOut);
    logic [57:0] s;
    logic        b;
    s = sIn;
    q = '0;
    for (int i = 0; i < 64; i++) begin
      b    = d[i] ^ s[38] ^ s[57];
      q[i] = b;
      s    = {s[56:0], descr ? d[i] : b};
    end
    sOut = s;
  endtask

  // Expected output of one non-bypassed beat on the main instance.
  task automatic modelBeat(input logic [NB*BW-1:0] din, input logic [57:0] sIn,
                           output logic [NB*BW-1:0] dout, output logic [57:0] sOut);
    logic [57:0] s;
    logic [63:0] q;
    s    = sIn;
    dout = '0;
    for (int k = 0; k < NB; k++) begin
      scrRun(din[k*BW +: 64], 1'b0, s, q, s);
      dout[k*BW +: BW] = {din[k*BW+64 +: 2], q};
    end
    sOut = s;
  endtask

  function automatic logic [NB*BW-1:0] randBeat();
    logic [NB*BW-1:0] r;
    r = '0;
    for (int k = 0; k < NB; k++) begin
      r[k*BW +: 64]   = {$urandom(), $urandom()};
      r[k*BW+64 +: 2] = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
    end
    return r;
  endfunction

  task automatic applyStimulus();
    @(negedge clock);
    reset         = 1'b1;
    enable        = 1'b1;
    bypass        = 1'b0;
    seedLoad      = 1'b0;
    busM.i_valid  = 1'b0;
    busM.i_data   = '0;
    busM.i_ready  = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; bypass = 1'b0; seedLoad = 1'b0;
    busM.i_valid = 1'b0; busM.i_data = '0; busM.i_ready = 1'b1;
    busZ.i_valid = 1'b0; busZ.i_data = '0; busZ.i_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    total++; if (busM.o_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_o_valid got=%b want=0", busM.o_valid); end
    total++; if (busM.o_data !== '0) begin bad++; $display("[TB] FAIL reset_o_data got=%h want=0", busM.o_data); end
    total++; if (errCountM !== 4'h0) begin bad++; $display("[TB] FAIL reset_err got=%h want=0", errCountM); end
    total++; if (busZ.o_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_z_o_valid got=%b want=0", busZ.o_valid); end
    total++; if (busM.o_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_o_ready got=%b want=1", busM.o_ready); end
    enable = 1'b0;
    #1;
    total++; if (busM.o_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_ready_disabled got=%b want=0", busM.o_ready); end
    enable = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_zero_seed();
    logic [2*BW-1:0] beat;
    beat = {2'b01, 64'h0, 2'b01, 64'h0};
    busZ.i_data  = beat;
    busZ.i_valid = 1'b1;
    @(negedge clock);
    busZ.i_valid = 1'b0;
    total++; if (busZ.o_valid !== 1'b1) begin bad++; $display("[TB] FAIL zero_seed_valid got=%b want=1", busZ.o_valid); end
    total++; if (busZ.o_data !== beat) begin bad++; $display("[TB] FAIL zero_seed_data got=%h want=%h", busZ.o_data, beat); end
    total++; if (errCountZ !== 16'h0) begin bad++; $display("[TB] FAIL zero_seed_err got=%h want=0", errCountZ); end
  endtask

  task automatic test_known_pattern();
    logic [NB*BW-1:0] din, dexp;
    logic [57:0]      s;
    applyStimulus();
    din = {2'b01, 64'h0, 2'b01, 64'h0, 2'b01, 64'h0};
    modelBeat(din, SEED_M, dexp, s);
    busM.i_data  = din;
    busM.i_valid = 1'b1;
    #1;
    total++; if (busM.o_valid !== 1'b0) begin bad++; $display("[TB] FAIL pattern_pre_valid got=%b want=0", busM.o_valid); end
    @(negedge clock);
    busM.i_valid = 1'b0;
    total++; if (busM.o_valid !== 1'b1) begin bad++; $display("[TB] FAIL pattern_valid got=%b want=1", busM.o_valid); end
    total++; if (busM.o_data[65:64] !== 2'b01) begin bad++; $display("[TB] FAIL pattern_hdr0 got=%b want=01", busM.o_data[65:64]); end
    total++; if (busM.o_data[63:0] !== ONES_ZERO_PAT) begin bad++; $display("[TB] FAIL pattern_blk0 got=%h want=%h", busM.o_data[63:0], ONES_ZERO_PAT); end
    total++; if (busM.o_data !== dexp) begin bad++; $display("[TB] FAIL pattern_beat got=%h want=%h", busM.o_data, dexp); end
    total++; if (errCountM !== 4'h0) begin bad++; $display("[TB] FAIL pattern_err got=%h want=0", errCountM); end
    @(negedge clock);
    total++; if (busM.o_valid !== 1'b0) begin bad++; $display("[TB] FAIL pattern_valid_fall got=%b want=0", busM.o_valid); end
  endtask

  task automatic test_stream_bypass();
    logic [NB*BW-1:0] inData [7];
    bit               inByp  [7];
    logic [57:0]      s;
    logic [63:0]      pin, pout, rec;
    applyStimulus();
    s = SEED_M;
    for (int b = 0; b <= 6; b++) begin
      @(negedge clock);
      if (b > 0) begin
        total++; if (busM.o_valid !== 1'b1) begin bad++; $display("[TB] FAIL stream_valid beat=%0d got=%b want=1", b-1, busM.o_valid); end
        for (int k = 0; k < NB; k++) begin
          pin  = inData[b-1][k*BW +: 64];
          pout = busM.o_data[k*BW +: 64];
          total++;
          if (busM.o_data[k*BW+64 +: 2] !== inData[b-1][k*BW+64 +: 2]) begin
            bad++; $display("[TB] FAIL stream_hdr beat=%0d blk=%0d got=%b want=%b", b-1, k, busM.o_data[k*BW+64 +: 2], inData[b-1][k*BW+64 +: 2]);
          end
          total++;
          if (inByp[b-1]) begin
            if (pout !== pin) begin bad++; $display("[TB] FAIL stream_bypass beat=%0d blk=%0d got=%h want=%h", b-1, k, pout, pin); end
            scrRun(pin, 1'b0, s, rec, s);
          end else begin
            scrRun(pout, 1'b1, s, rec, s);
            if (rec !== pin) begin bad++; $display("[TB] FAIL stream_descr beat=%0d blk=%0d got=%h want=%h", b-1, k, rec, pin); end
          end
        end
      end
      if (b < 6) begin
        inData[b]    = randBeat();
        inByp[b]     = (b == 2) || (b == 3);
        busM.i_data  = inData[b];
        bypass       = inByp[b];
        busM.i_valid = 1'b1;
      end else begin
        busM.i_valid = 1'b0;
        bypass       = 1'b0;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [NB*BW-1:0] a, b, c, expA, expB, expC;
    logic [57:0]      s;
    applyStimulus();
    a = randBeat(); b = randBeat(); c = randBeat();
    modelBeat(a, SEED_M, expA, s);
    modelBeat(b, s, expB, s);
    modelBeat(c, s, expC, s);
    busM.i_ready = 1'b0;
    busM.i_data  = a;
    busM.i_valid = 1'b1;
    @(negedge clock);
    busM.i_data = b;
    for (int i = 0; i < 5; i++) begin
      total++; if (busM.o_ready !== 1'b0) begin bad++; $display("[TB] FAIL stall_ready cyc=%0d got=%b want=0", i, busM.o_ready); end
      total++; if (busM.o_data !== expA || busM.o_valid !== 1'b1) begin bad++; $display("[TB] FAIL stall_data cyc=%0d got=%h want=%h", i, busM.o_data, expA); end
      @(negedge clock);
    end
    busM.i_ready = 1'b1;
    #1;
    total++; if (busM.o_ready !== 1'b1) begin bad++; $display("[TB] FAIL release_ready got=%b want=1", busM.o_ready); end
    @(negedge clock);
    busM.i_valid = 1'b0;
    total++; if (busM.o_data !== expB) begin bad++; $display("[TB] FAIL release_data got=%h want=%h", busM.o_data, expB); end
    @(negedge clock);
    total++; if (busM.o_valid !== 1'b0) begin bad++; $display("[TB] FAIL release_valid_fall got=%b want=0", busM.o_valid); end
    enable       = 1'b0;
    busM.i_data  = c;
    busM.i_valid = 1'b1;
    #1;
    total++; if (busM.o_ready !== 1'b0) begin bad++; $display("[TB] FAIL disable_ready got=%b want=0", busM.o_ready); end
    @(negedge clock);
    total++; if (busM.o_valid !== 1'b0) begin bad++; $display("[TB] FAIL disable_valid got=%b want=0", busM.o_valid); end
    enable = 1'b1;
    @(negedge clock);
    busM.i_valid = 1'b0;
    total++; if (busM.o_data !== expC) begin bad++; $display("[TB] FAIL enable_data got=%h want=%h", busM.o_data, expC); end
  endtask

  task automatic test_err_count();
    logic [3:0] expCnt;
    applyStimulus();
    busM.i_data  = {2'b10, 64'h0, 2'b11, 64'h0, 2'b00, 64'h0};
    busM.i_valid = 1'b1;
    @(negedge clock);
    expCnt = 4'd2;
    total++; if (errCountM !== expCnt) begin bad++; $display("[TB] FAIL err_mixed got=%h want=%h", errCountM, expCnt); end
    busM.i_data = {2'b00, 64'h1, 2'b11, 64'h2, 2'b00, 64'h3};
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      expCnt = (expCnt > 4'd12) ? 4'hF : expCnt + 4'd3;
      total++; if (errCountM !== expCnt) begin bad++; $display("[TB] FAIL err_accum step=%0d got=%h want=%h", i, errCountM, expCnt); end
    end
    busM.i_valid = 1'b0;
  endtask

  task automatic test_seed_load();
    logic [NB*BW-1:0] x, a, b, expX, expA, expB;
    logic [57:0]      s;
    applyStimulus();
    x = randBeat(); a = randBeat(); b = randBeat();
    modelBeat(x, SEED_M, expX, s);
    modelBeat(a, s, expA, s);
    modelBeat(b, SEED_M, expB, s);
    busM.i_data  = x;
    busM.i_valid = 1'b1;
    @(negedge clock);
    total++; if (busM.o_data !== expX) begin bad++; $display("[TB] FAIL seed_x got=%h want=%h", busM.o_data, expX); end
    busM.i_data = a;
    seedLoad    = 1'b1;
    @(negedge clock);
    seedLoad    = 1'b0;
    total++; if (busM.o_data !== expA) begin bad++; $display("[TB] FAIL seed_same_beat got=%h want=%h", busM.o_data, expA); end
    busM.i_data = b;
    @(negedge clock);
    busM.i_valid = 1'b0;
    total++; if (busM.o_data !== expB) begin bad++; $display("[TB] FAIL seed_next_beat got=%h want=%h", busM.o_data, expB); end
  endtask

  task automatic test_async_reset();
    applyStimulus();
    busM.i_data  = {2'b01, 64'h0, 2'b00, 64'h0, 2'b01, 64'h1234_5678_9ABC_DEF0};
    busM.i_valid = 1'b1;
    @(negedge clock);
    total++; if (errCountM !== 4'd1 || busM.o_valid !== 1'b1) begin bad++; $display("[TB] FAIL arst_pre got=%h/%b want=1/1", errCountM, busM.o_valid); end
    busM.i_data = randBeat();
    #2;
    reset = 1'b1;
    #1;
    total++; if (busM.o_valid !== 1'b0) begin bad++; $display("[TB] FAIL arst_valid got=%b want=0", busM.o_valid); end
    total++; if (busM.o_data !== '0) begin bad++; $display("[TB] FAIL arst_data got=%h want=0", busM.o_data); end
    total++; if (errCountM !== 4'h0) begin bad++; $display("[TB] FAIL arst_err got=%h want=0", errCountM); end
    @(negedge clock);
    reset       = 1'b0;
    busM.i_data = {2'b01, 64'h0, 2'b01, 64'h0, 2'b01, 64'h0};
    @(negedge clock);
    busM.i_valid = 1'b0;
    total++; if (busM.o_valid !== 1'b1 || busM.o_data[63:0] !== ONES_ZERO_PAT) begin bad++; $display("[TB] FAIL arst_seed got=%h want=%h", busM.o_data[63:0], ONES_ZERO_PAT); end
  endtask

  // Scenario sequence; every wait is a fixed number of cycles.
  initial begin
    test_reset();
    test_zero_seed();
    test_known_pattern();
    test_stream_bypass();
    test_back_to_back();
    test_err_count();
    test_seed_load();
    test_async_reset();
    @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
